// File: rtl/cmos_trig_monitor.sv
// Receive-side checker for the CMOS trigger line: period/width in ticks, pulse count, loss flag.
// Optional glitch filter between synchronizer and edge detector: CMOS_TRIG_GLITCH_FILT_EN.
module cmos_trig_monitor #(
    parameter int unsigned CLOCK_PERIOD = 10,
    parameter int unsigned TICK_NS      = 1000000,
    parameter int unsigned FILT_LEN     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig_in,
    input  logic [15:0] cfg_timeout,
    output logic [15:0] meas_period,
    output logic [15:0] meas_width,
    output logic        meas_valid,
    output logic [31:0] trig_cnt,
    output logic        trig_lost,
    output logic        trig_active
);

    localparam int unsigned CNT_TICK = TICK_NS / CLOCK_PERIOD;
    localparam int unsigned PW       = (CNT_TICK > 1) ? $clog2(CNT_TICK) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CNT_TICK - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHigh = 2'd1;
    localparam logic [1:0] StLow  = 2'd2;

    // Input synchronizer
    logic trig_meta_q, trig_sync_q;
    logic s, s_d_q;
    logic rise, fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
        end else begin
            trig_meta_q <= trig_in;
            trig_sync_q <= trig_meta_q;
        end
    end

`ifdef CMOS_TRIG_GLITCH_FILT_EN
    localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [FW-1:0] filt_cnt_q;
    logic          filt_lvl_q;

    // Level follows the synchronizer only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt_q <= '0;
            filt_lvl_q <= 1'b0;
        end else if (trig_sync_q == filt_lvl_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
            filt_cnt_q <= '0;
            filt_lvl_q <= trig_sync_q;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    assign s = filt_lvl_q;
`else
    logic unused_filt_len;
    assign unused_filt_len = ^FILT_LEN;
    assign s = trig_sync_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_d_q <= 1'b0;
        end else begin
            s_d_q <= s;
        end
    end

    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    // Timeout configuration register
    logic [15:0] cfg_timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_timeout_q <= '0;
        end else begin
            cfg_timeout_q <= cfg_timeout;
        end
    end

    // Elapsed-time counters: prescaler and tick count since the last rise
    logic [PW-1:0] p_q;
    logic [15:0]   ms_q;
    logic          p_wrap;
    logic [15:0]   ms_inc;
    logic [15:0]   elapsed;
    logic          timeout;

    assign p_wrap = (p_q == P_LAST);
    assign ms_inc = (ms_q == 16'hFFFF) ? ms_q : ms_q + 16'd1;
    // Tick count including the current cycle, so exactly P*CNT_TICK cycles reads as P.
    assign elapsed = p_wrap ? ms_inc : ms_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q  <= '0;
            ms_q <= '0;
        end else if (rise) begin
            p_q  <= '0;
            ms_q <= '0;
        end else if (p_wrap) begin
            p_q  <= '0;
            ms_q <= ms_inc;
        end else begin
            p_q <= p_q + 1'b1;
        end
    end

    // Main FSM and registered outputs
    logic [1:0]  state_q, state_d;
    logic [15:0] width_tmp_q, width_tmp_d;
    logic [15:0] meas_period_q, meas_period_d;
    logic [15:0] meas_width_q, meas_width_d;
    logic        meas_valid_q, meas_valid_d;
    logic [31:0] trig_cnt_q, trig_cnt_d;
    logic        trig_lost_q, trig_lost_d;

    assign timeout = (cfg_timeout_q != 16'd0) && (state_q != StIdle) && p_wrap &&
                     (({1'b0, ms_q} + 17'd1) == {1'b0, cfg_timeout_q});

    always_comb begin
        state_d       = state_q;
        width_tmp_d   = width_tmp_q;
        meas_period_d = meas_period_q;
        meas_width_d  = meas_width_q;
        meas_valid_d  = 1'b0;
        trig_cnt_d    = trig_cnt_q;
        trig_lost_d   = trig_lost_q;
        // A rise outranks a coincident timeout.
        if (rise) begin
            trig_cnt_d  = trig_cnt_q + 32'd1;
            trig_lost_d = 1'b0;
            state_d     = StHigh;
            if (state_q == StLow) begin
                meas_valid_d  = 1'b1;
                meas_period_d = elapsed;
                meas_width_d  = width_tmp_q;
            end
        end else if (timeout) begin
            trig_lost_d = 1'b1;
            state_d     = StIdle;
        end else if (fall && (state_q == StHigh)) begin
            width_tmp_d = elapsed;
            state_d     = StLow;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            width_tmp_q   <= '0;
            meas_period_q <= '0;
            meas_width_q  <= '0;
            meas_valid_q  <= 1'b0;
            trig_cnt_q    <= '0;
            trig_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            width_tmp_q   <= width_tmp_d;
            meas_period_q <= meas_period_d;
            meas_width_q  <= meas_width_d;
            meas_valid_q  <= meas_valid_d;
            trig_cnt_q    <= trig_cnt_d;
            trig_lost_q   <= trig_lost_d;
        end
    end

    assign meas_period = meas_period_q;
    assign meas_width  = meas_width_q;
    assign meas_valid  = meas_valid_q;
    assign trig_cnt    = trig_cnt_q;
    assign trig_lost   = trig_lost_q;
    assign trig_active = (state_q != StIdle);

endmodule

// File: tb/tb_cmos_trig_monitor.sv
// Bench for cmos_trig_monitor: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Honors CMOS_TRIG_GLITCH_FILT_EN.
module tb_cmos_trig_monitor;

    localparam int CLOCK_PERIOD = 10;
    localparam int TICK_NS      = 100;
    localparam int FILT_LEN     = 4;
    localparam int CNT_TICK     = TICK_NS / CLOCK_PERIOD;
`ifdef CMOS_TRIG_GLITCH_FILT_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        trig_in;
    logic [15:0] cfg_timeout;
    logic [15:0] meas_period;
    logic [15:0] meas_width;
    logic        meas_valid;
    logic [31:0] trig_cnt;
    logic        trig_lost;
    logic        trig_active;

    cmos_trig_monitor #(
        .CLOCK_PERIOD (CLOCK_PERIOD),
        .TICK_NS      (TICK_NS),
        .FILT_LEN     (FILT_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig_in     (trig_in),
        .cfg_timeout (cfg_timeout),
        .meas_period (meas_period),
        .meas_width  (meas_width),
        .meas_valid  (meas_valid),
        .trig_cnt    (trig_cnt),
        .trig_lost   (trig_lost),
        .trig_active (trig_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: event timestamps in clk edges since reset.
    int        m_e;
    int        m_last_rise;
    int        m_state;      // 0 idle, 1 high, 2 low
    bit        m_s, m_sd;    // level seen by the edge detector now / one edge earlier
    bit        m_hist[$];    // raw trig_in samples, newest last
    int        m_to_r;
    int        m_wtmp;
    int        m_period, m_width;
    bit        m_valid, m_lost;
    bit [31:0] m_cnt;

    task automatic model_reset();
        m_e = 0; m_last_rise = 0; m_state = 0;
        m_s = 1'b0; m_sd = 1'b0;
        m_hist.delete();
        repeat (FILT_LEN + 2) m_hist.push_back(1'b0);
        m_to_r = 0; m_wtmp = 0; m_period = 0; m_width = 0;
        m_valid = 1'b0; m_lost = 1'b0; m_cnt = '0;
    endtask

    task automatic model_step();
        bit rise, fall, tmo, s_new, all_flip;
        int n, el, elt, to_used;
        m_e++;
        m_hist.push_back(trig_in);
        if (m_hist.size() > FILT_LEN + 2) void'(m_hist.pop_front());
        n    = m_hist.size();
        rise = m_s && !m_sd;
        fall = !m_s && m_sd;
        if (!FILT_ON) begin
            s_new = m_hist[n-2];
        end else begin
            all_flip = 1'b1;
            for (int k = n - 1 - FILT_LEN; k <= n - 2; k++)
                if (m_hist[k] == m_s) all_flip = 1'b0;
            s_new = all_flip ? !m_s : m_s;
        end
        m_sd = m_s;
        m_s  = s_new;

        el  = m_e - m_last_rise;
        elt = el / CNT_TICK;
        if (elt > 65535) elt = 65535;
        to_used = m_to_r;
        m_to_r  = int'(cfg_timeout);
        tmo = (m_state != 0) && (to_used != 0) && (el == to_used * CNT_TICK);

        m_valid = 1'b0;
        if (rise) begin
            m_cnt  = m_cnt + 32'd1;
            m_lost = 1'b0;
            if (m_state == 2) begin
                m_valid  = 1'b1;
                m_period = elt;
                m_width  = m_wtmp;
            end
            m_state     = 1;
            m_last_rise = m_e;
        end else if (tmo) begin
            m_lost  = 1'b1;
            m_state = 0;
        end else if (fall && m_state == 1) begin
            m_wtmp  = elt;
            m_state = 2;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Observations used by the directed literal checks
    int        cyc = 0;
    int        obs_nvalid;
    int        obs_vcyc[$];
    int        obs_per[$];
    int        obs_wid[$];
    int        obs_rise_cyc, obs_lost_cyc;
    bit        obs_lost_any;
    logic [31:0] prev_cnt = '0;
    logic        prev_lost = 1'b0;

    task automatic clear_obs();
        obs_nvalid = 0;
        obs_vcyc.delete(); obs_per.delete(); obs_wid.delete();
        obs_rise_cyc = -1; obs_lost_cyc = -1; obs_lost_any = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check("meas_valid",  {31'b0, meas_valid},  {31'b0, m_valid});
        check("meas_period", {16'b0, meas_period}, 32'(m_period));
        check("meas_width",  {16'b0, meas_width},  32'(m_width));
        check("trig_cnt",    trig_cnt,             m_cnt);
        check("trig_lost",   {31'b0, trig_lost},   {31'b0, m_lost});
        check("trig_active", {31'b0, trig_active}, {31'b0, (m_state != 0)});
        if (meas_valid === 1'b1) begin
            obs_nvalid++;
            obs_vcyc.push_back(cyc);
            obs_per.push_back(int'(meas_period));
            obs_wid.push_back(int'(meas_width));
        end
        if (trig_cnt !== prev_cnt) obs_rise_cyc = cyc;
        if (trig_lost === 1'b1 && prev_lost !== 1'b1) obs_lost_cyc = cyc;
        if (trig_lost === 1'b1) obs_lost_any = 1'b1;
        prev_cnt  = trig_cnt;
        prev_lost = trig_lost;
    endtask

    task automatic hold(input bit v, input int n);
        trig_in = v;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int cnt0;

    initial begin
        rst = 1'b1;
        trig_in = 1'b0;
        cfg_timeout = '0;
        clear_obs();
        repeat (3) tick();
        check("rst_cnt", trig_cnt, 32'd0);
        check("rst_active", {31'b0, trig_active}, 32'd0);
        rst = 1'b0;

        // 1: 50-clk period, 20-clk high, no timeout
        hold(1'b0, 5);
        clear_obs();
        repeat (4) begin
            hold(1'b1, 20);
            hold(1'b0, 30);
        end
        check("t1_nvalid", 32'(obs_nvalid), 32'd3);
        if (obs_nvalid >= 2) begin
            check("t1_period", 32'(obs_per[0]), 32'd5);
            check("t1_width", 32'(obs_wid[0]), 32'd2);
            check("t1_spacing", 32'(obs_vcyc[1] - obs_vcyc[0]), 32'd50);
        end
        check("t1_cnt", trig_cnt, 32'd4);

        // 2: timeout 8 ticks with input left low
        cfg_timeout = 16'd8;
        hold(1'b1, 20);
        hold(1'b0, 30);
        clear_obs();
        hold(1'b1, 20);
        hold(1'b0, 100);
        check("t2_lost_delay", 32'(obs_lost_cyc - obs_rise_cyc), 32'd80);
        check("t2_lost", {31'b0, trig_lost}, 32'd1);
        check("t2_active", {31'b0, trig_active}, 32'd0);
        clear_obs();
        hold(1'b1, 20);
        hold(1'b0, 30);
        check("t2_relock_nvalid", 32'(obs_nvalid), 32'd0);
        check("t2_relock_lost", {31'b0, trig_lost}, 32'd0);
        hold(1'b1, 20);
        check("t2_second_nvalid", 32'(obs_nvalid), 32'd1);
        hold(1'b0, 30);

        // 3: input stuck high
        clear_obs();
        hold(1'b1, 100);
        check("t3_lost_delay", 32'(obs_lost_cyc - obs_rise_cyc), 32'd80);
        check("t3_active", {31'b0, trig_active}, 32'd0);
        hold(1'b0, 20);

        // 4: rise lands on the timeout cycle
        hold(1'b1, 20);
        clear_obs();
        hold(1'b0, 60);
        hold(1'b1, 20);
        hold(1'b0, 60);
        hold(1'b1, 20);
        check("t4_nvalid", 32'(obs_nvalid), 32'd2);
        if (obs_nvalid >= 1) check("t4_period", 32'(obs_per[0]), 32'd8);
        check("t4_no_lost", {31'b0, obs_lost_any}, 32'd0);
        hold(1'b0, 15);

        // 5: asynchronous reset while in LOW
        #2 rst = 1'b1;
        #1;
        check("t5_cnt", trig_cnt, 32'd0);
        check("t5_period", {16'b0, meas_period}, 32'd0);
        check("t5_active", {31'b0, trig_active}, 32'd0);
        check("t5_lost", {31'b0, trig_lost}, 32'd0);
        tick();
        rst = 1'b0;
        clear_obs();
        hold(1'b0, 5);
        hold(1'b1, 20);
        hold(1'b0, 30);
        check("t5_first_nvalid", 32'(obs_nvalid), 32'd0);
        check("t5_first_cnt", trig_cnt, 32'd1);
        hold(1'b1, 10);
        check("t5_second_nvalid", 32'(obs_nvalid), 32'd1);

        // 6: 2-clk glitch
        hold(1'b0, 40);
        cnt0 = int'(trig_cnt);
        hold(1'b1, 2);
        hold(1'b0, 20);
        check("t6_glitch_cnt", trig_cnt - 32'(cnt0), FILT_ON ? 32'd0 : 32'd1);

        // Randomized pulse trains, timeouts and occasional resets
        for (int i = 0; i < 250; i++) begin
            if (($urandom % 8) == 0) cfg_timeout = 16'($urandom_range(0, 12));
            if (($urandom % 60) == 0) do_reset();
            hold(1'b1, $urandom_range(1, 40));
            if (($urandom % 6) == 0) hold(1'b0, $urandom_range(60, 200));
            else hold(1'b0, $urandom_range(1, 40));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
